sd_dac_modulator: RTL and testbench
===================================

Name: sd_dac_modulator

Overview:
- Second-order sigma-delta modulator. Converts 16-bit signed PCM words, delivered at word rate over a valid/ready handshake, into a 1-bit stream on mclk1.
- It is the transmit-side counterpart of the sinc3 decimator and uses the same word rates:
  - mode[1]=0: word rate = mclk1/256.
  - mode[1]=1: word rate = mclk1/4096.
- Each sample is held for one word period (zero-order hold). The stream drives an external 1-bit DAC/RC filter or loops back to the decimator.

Parameters:
- IW, 20, width of integrator 1 (signed).
- OW, 22, width of integrator 2 (signed).
- FB, 32768, feedback magnitude (full-scale, 2^15).

Ports:
- mclk1 input 1: bit clock. All logic on posedge.
- reset input 1: asynchronous, active-high.
- mode input 2: mode[1] selects OSR (0 = 256, 1 = 4096). mode[0] is reserved and ignored.
- din input 16: PCM sample, two's complement.
- din_valid input 1: din valid this cycle.
- din_ready output 1: block accepts din this cycle.
- mdata1 output 1: modulator bitstream. 1 = +FB, 0 = -FB.
- word_clk output 1: word-rate clock, registered.
- underflow output 1: one-cycle pulse when a word boundary finds no pending sample.

Behaviour:
- Reset values: mdata1=0, din_ready=1, word_clk=0, underflow=0. Internally: word_count, hold_reg, hold_vld, active_reg, i1 and i2 all 0. Reset is honoured mid-operation; all state returns to these values on the next edge of reset.
- Word counter (12-bit word_count):
  - boundary = (mode[1] ? word_count==4095 : word_count[7:0]==255).
  - At boundary, word_count <= 0; otherwise it increments.
  - word_clk <= mode[1] ? word_count[11] : word_count[7].
  - A mode change mid-run needs no special handling; the next boundary follows the rule above. Example: switching to mode[1]=0 at count 300 gives the next wrap at 511.
- Input buffer: one-deep holding register plus the active sample register.
  - Accept when din_valid & din_ready: hold_reg <= din, hold_vld <= 1.
  - din_ready = ~hold_vld | boundary (combinational from state).
  - At boundary with hold_vld=1: active_reg <= hold_reg. hold_vld <= 0, unless an accept happens in the same cycle, in which case the new word goes to hold_reg and hold_vld stays 1.
  - At boundary with hold_vld=0: active_reg keeps its value and underflow=1 for that cycle.
  - Latency: a word accepted during a word period takes effect in active_reg at the next boundary. Its first effect on i1 is the cycle after that; on mdata1 it is one cycle later again.
- Modulator, every mclk1 cycle:
  - x = sign-extended active_reg.
  - v = mdata1 ? +FB : -FB.
  - i1 <= sat_IW(i1 + x - v).
  - i2 <= sat_OW(i2 + i1 - v), using the old i1.
  - mdata1 <= (i2_next >= 0).
- Saturation clamps to the signed min/max of the target width. Saturation is never expected for |x| <= 32767, but it is mandatory.
- Ones density over a long window = (x + 32768) / 65536, to within ±2 bits per word period once settled (more than 2 word periods after a change).
- Simultaneous events: boundary, accept and underflow resolve in the same cycle as defined above. underflow and an accept can coincide, because hold_vld=0 at the boundary while a new word is accepted into hold_reg.

Decomposition:
- Shared package sd_pkg:
  - OSR constants: OSR_M0=256, OSR_M1=4096.
  - FB.
  - The sat() function.
  - Width localparams IW and OW. The decimator can reuse them.
- One natural sub-module: sd_mod2_core (integrators, saturation, quantizer). Input x[15:0], output bit.
- The handshake/counter logic stays in the top level.

Test Plan:
- Reset: assert reset mid-stream at count 100 -> mdata1=0, din_ready=1, word_clk=0, underflow=0 immediately. Counter restarts at 0 after release.
- Handshake, mode 00, din_valid held high:
  - 0x4000 accepted at cycle 0; din_ready=0 afterwards.
  - A second word 0x1000 stalls until count 255, where it is accepted and 0x4000 moves to active_reg.
  - Exactly one accept per 256 cycles.
- Density: x=0 -> 128±2 ones per 256 cycles; x=0x4000 -> 192±2; x=0xC000 (-16384) -> 64±2; x=0x7FFF -> ≥254. Counts taken after 2 settling words.
- Underflow: supply one word, then none -> underflow pulses exactly 1 cycle at each following boundary (count 255). active_reg is unchanged and density is unchanged.
- Mode 1x: word_clk period = 4096 cycles with 50% duty. Switch mode to 00 at count 300 -> next wrap at count 511, then 256-cycle period.
- Loopback: feed mdata1 into sinc3 in mode 00 with constant x=0x2000 -> decimator output stable to within ±2 LSB of its value for that input, over 20 words, after 3 warm-up words.

Source files
------------

// File: rtl/sd_pkg.sv
// ----------------------------------------------------------------------------
// sd_pkg : shared sigma-delta constants and saturation helper.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sd_pkg;

   localparam int OSR_M0 = 256;
   localparam int OSR_M1 = 4096;
   localparam int IW     = 20;
   localparam int OW     = 22;
   localparam int FB     = 32768;

   // Working width for unsaturated sums; comfortably wider than OW + 2.
   localparam int SW     = 32;

   // Clamp v to the signed range of a w-bit value.
   function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v,
                                                input int                   w);
      logic signed [SW-1:0] one;
      logic signed [SW-1:0] hi;
      logic signed [SW-1:0] lo;
      one = SW'(1);
      hi  = (one <<< (w - 1)) - one;
      lo  = -hi - one;
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sd_mod2_core.sv
// ----------------------------------------------------------------------------
// sd_mod2_core : two saturating integrators and a 1-bit quantizer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sd_mod2_core
   import sd_pkg::*;
#(
   parameter int IW = sd_pkg::IW,
   parameter int OW = sd_pkg::OW,
   parameter int FB = sd_pkg::FB
) (
   input  logic               mclk1,
   input  logic               reset,
   input  logic signed [15:0] x,
   output logic               mdata
);

   logic signed [IW-1:0] i1;
   logic signed [OW-1:0] i2;
   logic signed [SW-1:0] v;
   logic signed [SW-1:0] i1_sum;
   logic signed [SW-1:0] i2_sum;
   logic signed [IW-1:0] i1_q;
   logic signed [OW-1:0] i2_q;

   // Second integrator deliberately consumes the pre-update i1.
   always_comb begin
      v      = mdata ? SW'(FB) : -SW'(FB);
      i1_sum = SW'(i1) + SW'(x) - v;
      i2_sum = SW'(i2) + SW'(i1) - v;
      i1_q   = IW'(sat(i1_sum, IW));
      i2_q   = OW'(sat(i2_sum, OW));
   end

   always_ff @(posedge mclk1 or posedge reset) begin
      if (reset) begin
         i1    <= '0;
         i2    <= '0;
         mdata <= 1'b0;
      end else begin
         i1    <= i1_q;
         i2    <= i2_q;
         mdata <= ~i2_q[OW-1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/sd_dac_modulator.sv
// ----------------------------------------------------------------------------
// sd_dac_modulator : PCM word handshake + 2nd-order sigma-delta bitstream.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sd_dac_modulator
   import sd_pkg::*;
#(
   parameter int IW = sd_pkg::IW,
   parameter int OW = sd_pkg::OW,
   parameter int FB = sd_pkg::FB
) (
   input  logic        mclk1,
   input  logic        reset,
   input  logic [1:0]  mode,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        mdata1,
   output logic        word_clk,
   output logic        underflow
);

   localparam logic [11:0] WRAP_M1 = 12'(OSR_M1 - 1);
   localparam logic [7:0]  WRAP_M0 = 8'(OSR_M0 - 1);

   logic [11:0]        word_count;
   logic [15:0]        hold_reg;
   logic               hold_vld;
   logic signed [15:0] active_reg;
   logic               boundary;
   logic               accept;
   logic               unused_mode0;

   assign unused_mode0 = mode[0];

   // Boundary is evaluated on the current mode only, so a mid-run mode change
   // simply lands on the next count that matches the new rule.
   assign boundary  = mode[1] ? (word_count == WRAP_M1) : (word_count[7:0] == WRAP_M0);
   assign din_ready = ~hold_vld | boundary;
   assign accept    = din_valid & din_ready;
   assign underflow = boundary & ~hold_vld;

   always_ff @(posedge mclk1 or posedge reset) begin
      if (reset) begin
         word_count <= '0;
         word_clk   <= 1'b0;
         hold_reg   <= '0;
         hold_vld   <= 1'b0;
         active_reg <= '0;
      end else begin
         word_count <= boundary ? 12'd0 : word_count + 12'd1;
         word_clk   <= mode[1] ? word_count[11] : word_count[7];
         if (accept)
            hold_reg <= din;
         if (boundary && hold_vld)
            active_reg <= hold_reg;
         // A same-cycle accept refills the holding slot as it is drained.
         if (accept)
            hold_vld <= 1'b1;
         else if (boundary)
            hold_vld <= 1'b0;
      end
   end

   sd_mod2_core #(
      .IW (IW),
      .OW (OW),
      .FB (FB)
   ) u_core (
      .mclk1 (mclk1),
      .reset (reset),
      .x     (active_reg),
      .mdata (mdata1)
   );

endmodule

`default_nettype wire

// File: tb/tb_sd_dac_modulator.sv
// ----------------------------------------------------------------------------
// tb_sd_dac_modulator : directed self-checking bench for sd_dac_modulator.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sd_dac_modulator;

   logic        mclk1     = 1'b0;
   logic        reset     = 1'b1;
   logic [1:0]  mode      = 2'b00;
   logic [15:0] din       = 16'h0000;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic        mdata1;
   logic        word_clk;
   logic        underflow;

   int vectors = 0;
   int errors  = 0;

   always #5 mclk1 = ~mclk1;

   sd_dac_modulator dut (
      .mclk1     (mclk1),
      .reset     (reset),
      .mode      (mode),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .mdata1    (mdata1),
      .word_clk  (word_clk),
      .underflow (underflow)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge mclk1);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] m);
      mode      = m;
      din_valid = 1'b0;
      din       = 16'h0000;
      @(posedge mclk1);
      #1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_count(input int target);
      int n = 0;
      while (dut.word_count != 12'(target) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) begin
         vectors++;
         errors++;
         $display("FAIL wait_count: count=%0d required=%0d", dut.word_count, target);
      end
   endtask

   task automatic test_reset();
      do_reset(2'b00);
      vectors++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", din_ready); end
      vectors++; if (mdata1 !== 1'b0) begin errors++; $display("FAIL rst_mdata: got %b expected 0", mdata1); end
      vectors++; if (word_clk !== 1'b0) begin errors++; $display("FAIL rst_wclk: got %b expected 0", word_clk); end
      vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_uflow: got %b expected 0", underflow); end
      vectors++; if (dut.word_count !== 12'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", dut.word_count); end
      din = 16'h4000; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      wait_count(200);
      vectors++; if (din_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_ready: got %b expected 0", din_ready); end
      vectors++; if (word_clk !== 1'b1) begin errors++; $display("FAIL pre_rst_wclk: got %b expected 1", word_clk); end
      #2 reset = 1'b1;
      #1;
      vectors++; if (din_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b expected 1", din_ready); end
      vectors++; if (word_clk !== 1'b0) begin errors++; $display("FAIL async_wclk: got %b expected 0", word_clk); end
      vectors++; if (mdata1 !== 1'b0) begin errors++; $display("FAIL async_mdata: got %b expected 0", mdata1); end
      vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL async_uflow: got %b expected 0", underflow); end
      tick();
      reset = 1'b0;
      vectors++; if (dut.hold_vld !== 1'b0) begin errors++; $display("FAIL rst_hold_vld: got %b expected 0", dut.hold_vld); end
      repeat (10) tick();
      vectors++; if (dut.word_count !== 12'd10) begin errors++; $display("FAIL restart_count: got %0d expected 10", dut.word_count); end
   endtask

   task automatic test_handshake();
      int accepts = 0;
      do_reset(2'b00);
      din = 16'h4000; din_valid = 1'b1;
      tick();
      vectors++; if (din_ready !== 1'b0) begin errors++; $display("FAIL hs_stall: got %b expected 0", din_ready); end
      din = 16'h1000;
      wait_count(255);
      vectors++; if (din_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_bnd: got %b expected 1", din_ready); end
      tick();
      vectors++; if (dut.active_reg !== 16'h4000) begin errors++; $display("FAIL hs_active: got %h expected 4000", dut.active_reg); end
      vectors++; if (dut.hold_reg !== 16'h1000) begin errors++; $display("FAIL hs_hold: got %h expected 1000", dut.hold_reg); end
      vectors++; if (din_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_after: got %b expected 0", din_ready); end
      din = 16'h2000;
      for (int i = 0; i < 512; i++) begin
         if (din_valid && din_ready) accepts++;
         tick();
      end
      din_valid = 1'b0;
      vectors++; if (accepts != 2) begin errors++; $display("FAIL hs_rate: got %0d accepts expected 2", accepts); end
      vectors++; if (dut.active_reg !== 16'h2000) begin errors++; $display("FAIL hs_active2: got %h expected 2000", dut.active_reg); end
   endtask

   task automatic density(input logic [15:0] x, input int words, input int lo,
                          input int hi, input string name);
      int ones = 0;
      do_reset(2'b00);
      din = x; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (255 + 512) tick();
      for (int i = 0; i < words * 256; i++) begin
         ones += int'(mdata1);
         tick();
      end
      vectors++;
      if (ones < lo || ones > hi) begin
         errors++;
         $display("FAIL %s: got %0d ones expected %0d..%0d", name, ones, lo, hi);
      end
   endtask

   task automatic test_density();
      density(16'h0000, 1, 126, 130, "dens_zero");
      density(16'h4000, 4, 760, 776, "dens_pos_half");
      density(16'hC000, 4, 248, 264, "dens_neg_half");
      density(16'h7FFF, 1, 254, 256, "dens_full");
   endtask

   task automatic test_underflow();
      int pulses;
      int ones = 0;
      int bad_pos;
      do_reset(2'b00);
      din = 16'h4000; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      wait_count(255);
      vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_pending: got %b expected 0", underflow); end
      tick();
      for (int w = 0; w < 6; w++) begin
         pulses  = 0;
         bad_pos = 0;
         for (int i = 0; i < 256; i++) begin
            if (underflow) begin
               pulses++;
               if (dut.word_count != 12'd255) bad_pos++;
            end
            if (w >= 2) ones += int'(mdata1);
            tick();
         end
         vectors++; if (pulses != 1 || bad_pos != 0) begin errors++; $display("FAIL uf_pulse: word %0d got %0d pulses (%0d misplaced) expected 1", w, pulses, bad_pos); end
      end
      vectors++; if (dut.active_reg !== 16'h4000) begin errors++; $display("FAIL uf_active: got %h expected 4000", dut.active_reg); end
      vectors++; if (ones < 760 || ones > 776) begin errors++; $display("FAIL uf_density: got %0d ones expected 760..776", ones); end
   endtask

   task automatic test_back_to_back();
      wait_count(255);
      vectors++; if (underflow !== 1'b1 || din_ready !== 1'b1) begin errors++; $display("FAIL b2b_bnd: got uf=%b rdy=%b expected 1 1", underflow, din_ready); end
      din = 16'h1234; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      vectors++; if (dut.hold_vld !== 1'b1 || dut.hold_reg !== 16'h1234) begin errors++; $display("FAIL b2b_hold: got vld=%b reg=%h expected 1 1234", dut.hold_vld, dut.hold_reg); end
      vectors++; if (dut.active_reg !== 16'h4000) begin errors++; $display("FAIL b2b_active_kept: got %h expected 4000", dut.active_reg); end
      wait_count(255);
      vectors++; if (underflow !== 1'b0) begin errors++; $display("FAIL b2b_no_uf: got %b expected 0", underflow); end
      tick();
      vectors++; if (dut.active_reg !== 16'h1234) begin errors++; $display("FAIL b2b_active_new: got %h expected 1234", dut.active_reg); end
   endtask

   task automatic wait_rise(output int cycles, output int high, output bit ok);
      logic prev;
      cycles = 0;
      high   = 0;
      ok     = 1'b0;
      prev   = word_clk;
      while (cycles < 10000) begin
         high += int'(word_clk);
         tick();
         cycles++;
         if (!prev && word_clk) begin
            ok = 1'b1;
            break;
         end
         prev = word_clk;
      end
   endtask

   task automatic test_mode1();
      int  cycles;
      int  high;
      int  n;
      bit  ok;
      do_reset(2'b10);
      wait_rise(cycles, high, ok);
      wait_rise(cycles, high, ok);
      vectors++; if (!ok || cycles != 4096) begin errors++; $display("FAIL m1_period: got %0d expected 4096", cycles); end
      vectors++; if (!ok || high != 2048) begin errors++; $display("FAIL m1_duty: got %0d high cycles expected 2048", high); end
      wait_count(300);
      mode = 2'b00;
      n = 0;
      while (!underflow && n < 1000) begin tick(); n++; end
      vectors++; if (n != 211 || dut.word_count !== 12'd511) begin errors++; $display("FAIL m_switch_wrap: got %0d cycles at count %0d expected 211 at 511", n, dut.word_count); end
      tick();
      n = 1;
      while (!underflow && n < 1000) begin tick(); n++; end
      vectors++; if (n != 256) begin errors++; $display("FAIL m0_period: got %0d expected 256", n); end
   endtask

   task automatic test_stream();
      int ones;
      do_reset(2'b00);
      din = 16'h2000; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (255 + 3 * 256) tick();
      for (int g = 0; g < 5; g++) begin
         ones = 0;
         for (int i = 0; i < 4 * 256; i++) begin
            ones += int'(mdata1);
            tick();
         end
         vectors++; if (ones < 632 || ones > 648) begin errors++; $display("FAIL stream_grp%0d: got %0d ones expected 632..648", g, ones); end
      end
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_density();
      test_underflow();
      test_back_to_back();
      test_mode1();
      test_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
